sram_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares the single SRAM controller between the instruction-fetch port (m0) and the data/load-store port (m1).
- Both master ports and the slave port use the same pulse-style bus handshake:
  - `req` is a 1-cycle pulse.
  - `resp` is a 1-cycle pulse.
  - `fault` is returned in the cycle the request reaches the slave.
- Provides round-robin arbitration, per-master buffering of one pending request, and return routing of resp, rdata and fault.

---
 rtl/sram_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the instruction-fetch
// master (m0) and the load/store master (m1). Round-robin arbitration, one
// buffered request per master, and resp/fault/rdata routing to the granted master.
module sram_arbiter #(
  parameter int AW   = 19,
  parameter int DW   = 32,
  parameter int ACCW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_w_rb,
  input  logic [ACCW-1:0] m0_acc,
  input  logic [DW-1:0]   m0_wdata,
  input  logic            m0_req,
  output logic            m0_resp,
  output logic            m0_fault,
  output logic [DW-1:0]   m0_rdata,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_w_rb,
  input  logic [ACCW-1:0] m1_acc,
  input  logic [DW-1:0]   m1_wdata,
  input  logic            m1_req,
  output logic            m1_resp,
  output logic            m1_fault,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   s_addr,
  output logic            s_w_rb,
  output logic [ACCW-1:0] s_acc,
  output logic [DW-1:0]   s_wdata,
  output logic            s_req,
  input  logic            s_resp,
  input  logic            s_fault,
  input  logic [DW-1:0]   s_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]      state;
  logic            gnt;
  logic            last;
  logic            busy;

  logic            pend0, pend1;
  logic [AW-1:0]   p0_addr, p1_addr;
  logic            p0_w_rb, p1_w_rb;
  logic [ACCW-1:0] p0_acc, p1_acc;
  logic [DW-1:0]   p0_wdata, p1_wdata;

  logic            out0, out1;
  logic            take0, take1;
  logic            e0, e1;
  logic            grant;
  logic            win;

  logic [AW-1:0]   win_addr;
  logic            win_w_rb;
  logic [ACCW-1:0] win_acc;
  logic [DW-1:0]   win_wdata;

  // A master is outstanding while buffered or while its transaction is in
  // flight; a new req from an outstanding master is dropped, not queued.
  assign busy  = (state != ST_IDLE);
  assign out0  = pend0 | (busy & ~gnt);
  assign out1  = pend1 | (busy & gnt);
  assign take0 = m0_req & ~out0;
  assign take1 = m1_req & ~out1;
  assign e0    = pend0 | take0;
  assign e1    = pend1 | take1;
  assign grant = (state == ST_IDLE) & (e0 | e1);

  // Round-robin pick: on a tie the master that was not granted last wins,
  // a lone requester wins outright.
  always_comb begin
    win = 1'b0;
    if (e0 && e1) begin
      win = ~last;
    end else begin
      win = e1;
    end
  end

  // Winner payload: the buffered slot takes priority over the live inputs.
  always_comb begin
    win_addr  = m0_addr;
    win_w_rb  = m0_w_rb;
    win_acc   = m0_acc;
    win_wdata = m0_wdata;
    if (win) begin
      if (pend1) begin
        win_addr  = p1_addr;
        win_w_rb  = p1_w_rb;
        win_acc   = p1_acc;
        win_wdata = p1_wdata;
      end else begin
        win_addr  = m1_addr;
        win_w_rb  = m1_w_rb;
        win_acc   = m1_acc;
        win_wdata = m1_wdata;
      end
    end else if (pend0) begin
      win_addr  = p0_addr;
      win_w_rb  = p0_w_rb;
      win_acc   = p0_acc;
      win_wdata = p0_wdata;
    end
  end

  // Transaction FSM: IDLE grants, ISSUE presents s_req for one cycle and
  // catches a fault, WAIT holds until the controller responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= ST_ISSUE;
            gnt   <= win;
            last  <= win;
          end
        end
        ST_ISSUE: begin
          state <= s_fault ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (s_resp) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Master 0 pending slot: captures any accepted request that is not issued
  // directly at this edge, and empties when its contents are granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend0    <= 1'b0;
      p0_addr  <= '0;
      p0_w_rb  <= 1'b0;
      p0_acc   <= '0;
      p0_wdata <= '0;
    end else if (grant && !win) begin
      pend0 <= 1'b0;
    end else if (take0) begin
      pend0    <= 1'b1;
      p0_addr  <= m0_addr;
      p0_w_rb  <= m0_w_rb;
      p0_acc   <= m0_acc;
      p0_wdata <= m0_wdata;
    end
  end

  // Master 1 pending slot: same capture/release rules as master 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend1    <= 1'b0;
      p1_addr  <= '0;
      p1_w_rb  <= 1'b0;
      p1_acc   <= '0;
      p1_wdata <= '0;
    end else if (grant && win) begin
      pend1 <= 1'b0;
    end else if (take1) begin
      pend1    <= 1'b1;
      p1_addr  <= m1_addr;
      p1_w_rb  <= m1_w_rb;
      p1_acc   <= m1_acc;
      p1_wdata <= m1_wdata;
    end
  end

  // Slave payload register: loaded on a grant and held through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_addr  <= '0;
      s_w_rb  <= 1'b0;
      s_acc   <= '0;
      s_wdata <= '0;
    end else if (grant) begin
      s_addr  <= win_addr;
      s_w_rb  <= win_w_rb;
      s_acc   <= win_acc;
      s_wdata <= win_wdata;
    end
  end

  // s_req is high exactly in ISSUE; responses are routed only inside their
  // valid window, and a reset cycle suppresses them entirely.
  assign s_req    = (state == ST_ISSUE);
  assign m0_fault = ~rst & (state == ST_ISSUE) & s_fault & ~gnt;
  assign m1_fault = ~rst & (state == ST_ISSUE) & s_fault &  gnt;
  assign m0_resp  = ~rst & (state == ST_WAIT)  & s_resp  & ~gnt;
  assign m1_resp  = ~rst & (state == ST_WAIT)  & s_resp  &  gnt;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus for sram_arbiter with hand-computed
// expectations. Inputs change 1ns after the rising edge and outputs are
// sampled 1ns later, well clear of the next edge.
// Access-size encoding used here: 2'd1 = 2 bytes, 2'd2 = 4 bytes.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] m0_addr, m1_addr, s_addr;
  logic        m0_w_rb, m1_w_rb, s_w_rb;
  logic [1:0]  m0_acc, m1_acc, s_acc;
  logic [31:0] m0_wdata, m1_wdata, s_wdata;
  logic        m0_req, m1_req, s_req;
  logic        m0_resp, m1_resp, s_resp;
  logic        m0_fault, m1_fault, s_fault;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;

  int tests = 0;
  int fails = 0;
  logic exp_m;

  sram_arbiter #(.AW(19), .DW(32), .ACCW(2)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata),
    .m0_req(m0_req), .m0_resp(m0_resp), .m0_fault(m0_fault), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata),
    .m1_req(m1_req), .m1_resp(m1_resp), .m1_fault(m1_fault), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_req(s_req), .s_resp(s_resp), .s_fault(s_fault), .s_rdata(s_rdata)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and drop all pulse inputs
  task nextCycle;
    @(posedge clk);
    #1;
    m0_req  = 1'b0;
    m1_req  = 1'b0;
    s_resp  = 1'b0;
    s_fault = 1'b0;
  endtask

  // Present a one-cycle request with its payload on the chosen master
  task applyStimulus(input logic master, input logic [18:0] addr, input logic w_rb,
                     input logic [1:0] acc, input logic [31:0] wdata);
    if (master) begin
      m1_addr = addr; m1_w_rb = w_rb; m1_acc = acc; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_addr = addr; m0_w_rb = w_rb; m0_acc = acc; m0_wdata = wdata; m0_req = 1'b1;
    end
  endtask

  // One comparison against a hand-computed value
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One reset edge, released right after it
  task resetDut;
    nextCycle;
    rst = 1'b1;
    nextCycle;
    rst = 1'b0;
  endtask

  // Runaway guard
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    rst = 1'b1;
    m0_addr = '0; m0_w_rb = 1'b0; m0_acc = '0; m0_wdata = '0; m0_req = 1'b0;
    m1_addr = '0; m1_w_rb = 1'b0; m1_acc = '0; m1_wdata = '0; m1_req = 1'b0;
    s_resp = 1'b0; s_fault = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_s_req",    s_req,    0);
    checkOutput("rst_s_addr",   s_addr,   0);
    checkOutput("rst_s_wdata",  s_wdata,  0);
    checkOutput("rst_m0_resp",  m0_resp,  0);
    checkOutput("rst_m1_fault", m1_fault, 0);

    // Single read from m0
    nextCycle;
    applyStimulus(1'b0, 19'h00010, 1'b0, 2'd2, 32'h0);
    #1 checkOutput("t1_sreq_T", s_req, 0);
    nextCycle;
    #1;
    checkOutput("t1_sreq_T1", s_req,  1);
    checkOutput("t1_s_addr",  s_addr, 32'h10);
    checkOutput("t1_s_w_rb",  s_w_rb, 0);
    checkOutput("t1_s_acc",   s_acc,  2);
    for (int i = 0; i < 3; i++) begin
      nextCycle;
      #1;
      checkOutput("t1_wait_sreq", s_req,   0);
      checkOutput("t1_wait_resp", m0_resp, 0);
      checkOutput("t1_hold_addr", s_addr,  32'h10);
    end
    nextCycle;
    s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("t1_m0_resp",  m0_resp,  1);
    checkOutput("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("t1_m1_resp",  m1_resp,  0);

    // Simultaneous requests right after reset: m0 first, m1 buffered
    resetDut;
    nextCycle;
    applyStimulus(1'b0, 19'h00100, 1'b0, 2'd2, 32'h0);
    applyStimulus(1'b1, 19'h00200, 1'b1, 2'd1, 32'hCAFE0001);
    nextCycle;
    m1_addr = 19'h003FF; m1_wdata = 32'h0;
    #1;
    checkOutput("t2_first_sreq", s_req,  1);
    checkOutput("t2_first_addr", s_addr, 32'h100);
    nextCycle;
    nextCycle;
    s_resp = 1'b1;
    #1;
    checkOutput("t2_m0_resp", m0_resp, 1);
    checkOutput("t2_m1_resp", m1_resp, 0);
    nextCycle;
    #1 checkOutput("t2_idle_gap", s_req, 0);
    nextCycle;
    #1;
    checkOutput("t2_m1_sreq",  s_req,   1);
    checkOutput("t2_m1_addr",  s_addr,  32'h200);
    checkOutput("t2_m1_w_rb",  s_w_rb,  1);
    checkOutput("t2_m1_acc",   s_acc,   1);
    checkOutput("t2_m1_wdata", s_wdata, 32'hCAFE0001);
    nextCycle;
    nextCycle;
    s_resp = 1'b1;
    #1;
    checkOutput("t2_m1_resp", m1_resp, 1);
    checkOutput("t2_m0_quiet", m0_resp, 0);
    nextCycle;
    applyStimulus(1'b0, 19'h00101, 1'b0, 2'd2, 32'h0);
    applyStimulus(1'b1, 19'h00201, 1'b0, 2'd2, 32'h0);
    nextCycle;
    #1;
    checkOutput("t2_tie2_sreq", s_req,  1);
    checkOutput("t2_tie2_addr", s_addr, 32'h101);

    // Round-robin with both masters re-requesting right after each response
    resetDut;
    nextCycle;
    applyStimulus(1'b0, 19'h00AAA, 1'b0, 2'd2, 32'h0);
    applyStimulus(1'b1, 19'h00BBB, 1'b0, 2'd2, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_m = i[0];
      nextCycle;
      #1;
      checkOutput("rr_sreq", s_req, 1);
      checkOutput("rr_addr", s_addr, exp_m ? 32'hBBB : 32'hAAA);
      nextCycle;
      nextCycle;
      s_resp = 1'b1;
      #1;
      checkOutput("rr_resp",  exp_m ? m1_resp : m0_resp, 1);
      checkOutput("rr_other", exp_m ? m0_resp : m1_resp, 0);
      nextCycle;
      applyStimulus(exp_m, exp_m ? 19'h00BBB : 19'h00AAA, 1'b0, 2'd2, 32'h0);
    end

    // Fault path on m1, then stray resp/fault outside their windows
    resetDut;
    nextCycle;
    applyStimulus(1'b1, 19'h00001, 1'b0, 2'd1, 32'h0);
    nextCycle;
    s_fault = 1'b1;
    #1;
    checkOutput("t4_sreq",     s_req,    1);
    checkOutput("t4_m1_fault", m1_fault, 1);
    checkOutput("t4_m0_fault", m0_fault, 0);
    checkOutput("t4_m1_resp",  m1_resp,  0);
    nextCycle;
    s_resp = 1'b1;
    applyStimulus(1'b0, 19'h00040, 1'b0, 2'd2, 32'h0);
    #1;
    checkOutput("t4_fault_once", m1_fault, 0);
    checkOutput("t4_stray_resp", m1_resp,  0);
    checkOutput("t4_idle_sreq",  s_req,    0);
    nextCycle;
    #1;
    checkOutput("t4_m0_sreq", s_req,  1);
    checkOutput("t4_m0_addr", s_addr, 32'h40);
    nextCycle;
    s_fault = 1'b1;
    #1 checkOutput("t4_stray_fault", m0_fault, 0);
    nextCycle;
    s_resp = 1'b1;
    #1 checkOutput("t4_m0_resp", m0_resp, 1);

    // m1 request arrives during m0's WAIT; a second m1 request is dropped
    nextCycle;
    applyStimulus(1'b0, 19'h00050, 1'b0, 2'd2, 32'h0);
    nextCycle;
    #1 checkOutput("t5_m0_sreq", s_req, 1);
    nextCycle;
    applyStimulus(1'b1, 19'h00060, 1'b1, 2'd2, 32'h12345678);
    nextCycle;
    applyStimulus(1'b1, 19'h00070, 1'b1, 2'd2, 32'h0BADF00D);
    nextCycle;
    s_resp = 1'b1;
    #1 checkOutput("t5_m0_resp", m0_resp, 1);
    nextCycle;
    #1 checkOutput("t5_idle_gap", s_req, 0);
    nextCycle;
    #1;
    checkOutput("t5_m1_sreq",  s_req,   1);
    checkOutput("t5_m1_addr",  s_addr,  32'h60);
    checkOutput("t5_m1_w_rb",  s_w_rb,  1);
    checkOutput("t5_m1_wdata", s_wdata, 32'h12345678);
    nextCycle;
    nextCycle;
    s_resp = 1'b1;
    #1 checkOutput("t5_m1_resp", m1_resp, 1);
    nextCycle;
    nextCycle;
    #1 checkOutput("t5_dropped", s_req, 0);

    // Reset during WAIT with m1 buffered
    nextCycle;
    applyStimulus(1'b0, 19'h00080, 1'b0, 2'd2, 32'h0);
    nextCycle;
    nextCycle;
    applyStimulus(1'b1, 19'h00090, 1'b0, 2'd2, 32'h0);
    nextCycle;
    rst = 1'b1; s_resp = 1'b1;
    #1;
    checkOutput("t6_rst_m0_resp", m0_resp, 0);
    checkOutput("t6_rst_m1_resp", m1_resp, 0);
    nextCycle;
    rst = 1'b0;
    #1;
    checkOutput("t6_sreq_after", s_req,  0);
    checkOutput("t6_addr_after", s_addr, 0);
    nextCycle;
    #1 checkOutput("t6_pend_clear_a", s_req, 0);
    nextCycle;
    applyStimulus(1'b1, 19'h000A0, 1'b0, 2'd2, 32'h0);
    #1 checkOutput("t6_pend_clear_b", s_req, 0);
    nextCycle;
    #1;
    checkOutput("t6_m1_sreq", s_req,  1);
    checkOutput("t6_m1_addr", s_addr, 32'hA0);
    nextCycle;
    nextCycle;
    s_resp = 1'b1;
    #1 checkOutput("t6_m1_resp", m1_resp, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
